cascaded_counter: RTL and testbench

- Three-stage synchronous cascaded counter driven by a single clock.
- Stage 1 (out1) is a mod-MOD1 counter.
- Stage 2 (out2) is a mod-MOD2 counter that advances once per stage-1 wrap.
- Stage 3 (out3) is a toggle flag that flips once per full stage-1 × stage-2 cycle.
- Used as a timebase/prescaler: out1 is the fine count, out2 the coarse count, out3 a divided square wave with period 2·MOD1·MOD2 clocks.

---
 rtl/cascaded_counter_pkg.sv | 25 ++
 rtl/cascaded_counter_mod_counter.sv | 49 ++++
 rtl/cascaded_counter.sv | 82 ++++++++
 tb/tb_cascaded_counter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cascaded_counter_pkg.sv
// ---------------------------------------------------------------------------
// cascaded_counter_pkg
// Shared constants for the three-stage cascaded counter: output widths,
// default moduli, and the legal modulus ranges enforced at elaboration.
// No ports (package).
// ---------------------------------------------------------------------------
package cascaded_counter_pkg;

   localparam int W1 = 4;
   localparam int W2 = 2;

   localparam int MOD1_DEFAULT = 10;
   localparam int MOD2_DEFAULT = 4;

   localparam int MOD1_MIN = 2;
   localparam int MOD1_MAX = 16;
   localparam int MOD2_MIN = 2;
   localparam int MOD2_MAX = 4;

   // True when a modulus sits inside its inclusive legal range.
   function automatic bit modInRange(input int m, input int lo, input int hi);
      return (m >= lo) && (m <= hi);
   endfunction

endpackage

// File: rtl/cascaded_counter_mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter
// Enabled modulo-MOD up-counter with a terminal-count flag.
// Ports:
//   clk   - clock, rising-edge active
//   reset - synchronous active-high clear
//   en    - advance the count on this edge
//   count - registered count value 0..MOD-1
//   tc    - en && (count == MOD-1); the edge on which the counter wraps
// Out-of-range values (>= MOD) keep counting and fall back to 0 through
// natural width overflow.
// ---------------------------------------------------------------------------
module mod_counter #(
   parameter int WIDTH = 4,
   parameter int MOD   = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             tc
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

   logic [WIDTH-1:0] countQ;
   logic [WIDTH-1:0] countD;

   // Next-count: hold unless enabled, then either wrap at LAST or step by one.
   always_comb begin
      countD = countQ;
      if (en) begin
         countD = (countQ == LAST) ? '0 : countQ + 1'b1;
      end
   end

   // Count register; reset wins over any enabled advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         countQ <= '0;
      end else begin
         countQ <= countD;
      end
   end

   assign count = countQ;
   assign tc    = en && (countQ == LAST);

endmodule

// File: rtl/cascaded_counter.sv
// ---------------------------------------------------------------------------
// cascaded_counter
// Three-stage prescaler/timebase: a fine mod-MOD1 count, a coarse mod-MOD2
// count advancing once per fine wrap, and a toggle flag that flips once per
// full MOD1*MOD2 cycle (square wave of period 2*MOD1*MOD2 clocks).
// Ports:
//   clk   - clock, rising-edge active
//   reset - synchronous active-high reset, clears all stages
//   out1  - stage-1 count (registered)
//   out2  - stage-2 count (registered)
//   out3  - stage-3 toggle flag (registered)
// ---------------------------------------------------------------------------
module cascaded_counter
   import cascaded_counter_pkg::*;
#(
   parameter int MOD1 = MOD1_DEFAULT,
   parameter int MOD2 = MOD2_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   output logic [W1-1:0] out1,
   output logic [W2-1:0] out2,
   output logic          out3
);

   // Refuse to elaborate with moduli the fixed output widths cannot hold.
   if (!modInRange(MOD1, MOD1_MIN, MOD1_MAX)) begin : gBadMod1
      $error("cascaded_counter: MOD1=%0d outside %0d..%0d", MOD1, MOD1_MIN, MOD1_MAX);
   end
   if (!modInRange(MOD2, MOD2_MIN, MOD2_MAX)) begin : gBadMod2
      $error("cascaded_counter: MOD2=%0d outside %0d..%0d", MOD2, MOD2_MIN, MOD2_MAX);
   end

   logic tc1;
   logic tc2;
   logic out3Q;
   logic out3D;

   // Stage 1 advances every edge; its terminal count feeds stage 2.
   mod_counter #(
      .WIDTH (W1),
      .MOD   (MOD1)
   ) uStage1 (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .count (out1),
      .tc    (tc1)
   );

   // Stage 2 advances once per stage-1 wrap, so its tc marks the full cycle.
   mod_counter #(
      .WIDTH (W2),
      .MOD   (MOD2)
   ) uStage2 (
      .clk   (clk),
      .reset (reset),
      .en    (tc1),
      .count (out2),
      .tc    (tc2)
   );

   // Stage 3 flips on the same edge where both lower stages wrap together.
   always_comb begin
      out3D = out3Q;
      if (tc2) begin
         out3D = ~out3Q;
      end
   end

   // Toggle flag register.
   always_ff @(posedge clk) begin
      if (reset) begin
         out3Q <= 1'b0;
      end else begin
         out3Q <= out3D;
      end
   end

   assign out3 = out3Q;

endmodule

// File: tb/tb_cascaded_counter.sv
// ---------------------------------------------------------------------------
// tb_cascaded_counter
// Drives a default-parameter instance (10 x 4) and a 16 x 2 instance from the
// same clock and reset, and compares both against an edge-count model:
// with n edges since the last reset edge, out1 = n mod MOD1,
// out2 = (n / MOD1) mod MOD2, out3 = (n / (MOD1*MOD2)) mod 2.
// ---------------------------------------------------------------------------
module tb_cascaded_counter;

   localparam int A1 = 10;
   localparam int A2 = 4;
   localparam int B1 = 16;
   localparam int B2 = 2;

   logic       clk;
   logic       reset;
   logic [3:0] out1A;
   logic [1:0] out2A;
   logic       out3A;
   logic [3:0] out1B;
   logic [1:0] out2B;
   logic       out3B;

   int numChecks;
   int numFails;
   int n;

   cascaded_counter #(
      .MOD1 (A1),
      .MOD2 (A2)
   ) dutA (
      .clk   (clk),
      .reset (reset),
      .out1  (out1A),
      .out2  (out2A),
      .out3  (out3A)
   );

   cascaded_counter #(
      .MOD1 (B1),
      .MOD2 (B2)
   ) dutB (
      .clk   (clk),
      .reset (reset),
      .out1  (out1B),
      .out2  (out2B),
      .out3  (out3B)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: outputs as a function of edges since reset.
   function automatic int refOut1(input int edges, input int m1);
      return edges % m1;
   endfunction

   function automatic int refOut2(input int edges, input int m1, input int m2);
      return (edges / m1) % m2;
   endfunction

   function automatic int refOut3(input int edges, input int m1, input int m2);
      return (edges / (m1 * m2)) % 2;
   endfunction

   // One comparison point: counts it and reports any miscompare.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      numChecks++;
      assert (observed === expected) else begin
         numFails++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Compare both instances with the model for the current edge count.
   task automatic checkAll();
      checkOutput("modelA.out1", 32'(out1A), 32'(refOut1(n, A1)));
      checkOutput("modelA.out2", 32'(out2A), 32'(refOut2(n, A1, A2)));
      checkOutput("modelA.out3", 32'(out3A), 32'(refOut3(n, A1, A2)));
      checkOutput("modelB.out1", 32'(out1B), 32'(refOut1(n, B1)));
      checkOutput("modelB.out2", 32'(out2B), 32'(refOut2(n, B1, B2)));
      checkOutput("modelB.out3", 32'(out3B), 32'(refOut3(n, B1, B2)));
   endtask

   // Drive reset, take one rising edge, sample 1 unit later, update the model.
   task automatic applyStimulus(input logic rst);
      reset = rst;
      @(posedge clk);
      #1;
      if (rst) begin
         n = 0;
      end else begin
         n++;
      end
      checkAll();
   endtask

   initial begin
      int togglesA;
      int changes2A;
      int togglesB;
      int expTogglesB;
      logic prev3A;
      logic [1:0] prev2A;
      logic prev3B;

      numChecks = 0;
      numFails  = 0;
      n         = 0;
      reset     = 1'b1;

      $display("[TB] reset phase");
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1);
         checkOutput("rst.out1", 32'(out1A), 32'd0);
         checkOutput("rst.out2", 32'(out2A), 32'd0);
         checkOutput("rst.out3", 32'(out3A), 32'd0);
      end

      $display("[TB] first 80 edges after release");
      for (int k = 1; k <= 80; k++) begin
         applyStimulus(1'b0);
         if (k <= 9) begin
            checkOutput("rel.out1", 32'(out1A), 32'(k));
            checkOutput("rel.out2", 32'(out2A), 32'd0);
            checkOutput("rel.out3", 32'(out3A), 32'd0);
         end
         if (k == 10) begin
            checkOutput("e10.out1", 32'(out1A), 32'd0);
            checkOutput("e10.out2", 32'(out2A), 32'd1);
         end
         if (k == 40) begin
            checkOutput("e40.out1", 32'(out1A), 32'd0);
            checkOutput("e40.out2", 32'(out2A), 32'd0);
            checkOutput("e40.out3", 32'(out3A), 32'd1);
         end
         if (k == 80) begin
            checkOutput("e80.out3", 32'(out3A), 32'd0);
         end
         if (k == 15) begin
            checkOutput("B.e15.out1", 32'(out1B), 32'd15);
         end
         if (k == 16) begin
            checkOutput("B.e16.out1", 32'(out1B), 32'd0);
            checkOutput("B.e16.out2", 32'(out2B), 32'd1);
         end
         if (k == 32) begin
            checkOutput("B.e32.out3", 32'(out3B), 32'd1);
         end
      end

      $display("[TB] mid-count reset at out1=5 out2=2 out3=1");
      for (int k = 0; k < 65; k++) begin
         applyStimulus(1'b0);
      end
      checkOutput("pre.out1", 32'(out1A), 32'd5);
      checkOutput("pre.out2", 32'(out2A), 32'd2);
      checkOutput("pre.out3", 32'(out3A), 32'd1);
      applyStimulus(1'b1);
      checkOutput("mid.out1", 32'(out1A), 32'd0);
      checkOutput("mid.out2", 32'(out2A), 32'd0);
      checkOutput("mid.out3", 32'(out3A), 32'd0);
      applyStimulus(1'b0);
      checkOutput("resume.out1", 32'(out1A), 32'd1);

      $display("[TB] randomized run lengths and reset pulses");
      for (int t = 0; t < 6; t++) begin
         int runLen;
         int rstLen;
         runLen = int'($urandom_range(150, 1));
         rstLen = int'($urandom_range(3, 1));
         for (int k = 0; k < runLen; k++) begin
            applyStimulus(1'b0);
         end
         for (int k = 0; k < rstLen; k++) begin
            applyStimulus(1'b1);
         end
      end
      for (int k = 0; k < int'($urandom_range(79, 0)); k++) begin
         applyStimulus(1'b0);
      end

      $display("[TB] 400-edge toggle census");
      togglesA    = 0;
      changes2A   = 0;
      togglesB    = 0;
      expTogglesB = 0;
      prev3A      = out3A;
      prev2A      = out2A;
      prev3B      = out3B;
      for (int k = 0; k < 400; k++) begin
         applyStimulus(1'b0);
         if (out3A !== prev3A) togglesA++;
         if (out2A !== prev2A) changes2A++;
         if (out3B !== prev3B) togglesB++;
         if (refOut3(n, B1, B2) != refOut3(n - 1, B1, B2)) expTogglesB++;
         prev3A = out3A;
         prev2A = out2A;
         prev3B = out3B;
      end
      checkOutput("census.togglesA", 32'(togglesA), 32'd10);
      checkOutput("census.changes2A", 32'(changes2A), 32'd40);
      checkOutput("census.togglesB", 32'(togglesB), 32'(expTogglesB));

      $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
      $finish;
   end

endmodule
